// File: rtl/sb_transaction_tx_if.sv
// Sideband transaction transmitter bus bundle.
// Groups the request/field inputs coming from the control unit and the
// status/symbol outputs going back to it and to the sideband lane.
//   sb_en      : link connected; low aborts and holds the transmitter idle
//   at_req/lt_req : AT / LT frame requests, sampled while busy is low
//   at_cmd, at_rw, at_addr, at_len, at_data : AT frame fields
//   busy, done, sym_start : frame status
//   sbtx       : 10-bit sideband symbol {1'b1, byte, 1'b0}
// master = requester (control unit) side, slave = transmitter side.
interface sb_transaction_tx_if #(
    parameter int MAX_DATA = 3
);
    logic                    sb_en;
    logic                    at_req;
    logic                    at_cmd;
    logic                    at_rw;
    logic [7:0]              at_addr;
    logic [6:0]              at_len;
    logic [8*MAX_DATA-1:0]   at_data;
    logic                    lt_req;
    logic                    busy;
    logic                    done;
    logic                    sym_start;
    logic [9:0]              sbtx;

    modport master (
        output sb_en, at_req, at_cmd, at_rw, at_addr, at_len, at_data, lt_req,
        input  busy, done, sym_start, sbtx
    );

    modport slave (
        input  sb_en, at_req, at_cmd, at_rw, at_addr, at_len, at_data, lt_req,
        output busy, done, sym_start, sbtx
    );
endinterface

// File: rtl/sb_transaction_tx.sv
// Sideband transaction transmitter.
// Builds and serialises AT command/response frames and LT link-state frames
// onto the sideband lane, one 10-bit symbol every SYM_CYCLES clocks.
// Ports:
//   sb_clk : sideband clock
//   rst    : asynchronous reset, active-high
//   sb     : slave side of sb_transaction_tx_if (requests, fields, status,
//            sbtx symbol output)
// AT frame: DLE STX ADDR LEN DATA*N CRC_L CRC_H DLE ETX, with DLE (0xFE)
// stuffing after any ADDR/LEN/DATA/CRC byte equal to 0xFE.
// LT frame: DLE LSE CLSE.
module sb_transaction_tx #(
    parameter int SYM_CYCLES = 10,
    parameter int MAX_DATA   = 3
) (
    input  logic               sb_clk,
    input  logic               rst,
    sb_transaction_tx_if.slave sb
);

    localparam int SW = $clog2(SYM_CYCLES + 1);
    localparam int CW = $clog2(MAX_DATA + 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(SYM_CYCLES - 1);

    localparam logic [7:0] B_DLE     = 8'hFE;
    localparam logic [7:0] B_STX_CMD = 8'h05;
    localparam logic [7:0] B_STX_RSP = 8'h04;
    localparam logic [7:0] B_ETX     = 8'h40;
    localparam logic [7:0] B_LSE     = 8'h80;
    localparam logic [7:0] B_CLSE    = 8'h7F;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] DLE_S = 4'd1;
    localparam logic [3:0] STX   = 4'd2;
    localparam logic [3:0] ADDR  = 4'd3;
    localparam logic [3:0] LEN   = 4'd4;
    localparam logic [3:0] DATA  = 4'd5;
    localparam logic [3:0] CRC_L = 4'd6;
    localparam logic [3:0] CRC_H = 4'd7;
    localparam logic [3:0] DLE_E = 4'd8;
    localparam logic [3:0] ETX   = 4'd9;
    localparam logic [3:0] LSE   = 4'd10;
    localparam logic [3:0] CLSE  = 4'd11;

    logic [3:0]            state_q, state_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         n_q, n_d;
    logic                  stuff_q, stuff_d;
    logic                  lt_q, lt_d;
    logic [15:0]           crc_q, crc_d;
    logic                  cmd_q, cmd_d;
    logic [7:0]            addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [8*MAX_DATA-1:0] data_q, data_d;

    logic       busy;
    logic       sym_last;
    logic       accept;
    logic       stuffable;
    logic       crc_fed;
    logic [7:0] cur_byte;

    // CRC-16/0x8005, MSB-first over one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15] ^ b[7 - i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                  c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign busy     = (state_q != IDLE);
    assign sym_last = (cnt_q == SYM_LAST);
    assign accept   = !busy && sb.sb_en && (sb.at_req || sb.lt_req);

    // Byte on the lane for the current symbol, plus whether it is subject to
    // DLE stuffing and whether it contributes to the CRC.
    always_comb begin
        cur_byte  = B_DLE;
        stuffable = 1'b0;
        crc_fed   = 1'b0;
        case (state_q)
            STX: begin
                cur_byte = cmd_q ? B_STX_CMD : B_STX_RSP;
                crc_fed  = 1'b1;
            end
            ADDR: begin
                cur_byte  = addr_q;
                stuffable = 1'b1;
                crc_fed   = 1'b1;
            end
            LEN: begin
                cur_byte  = len_q;
                stuffable = 1'b1;
                crc_fed   = 1'b1;
            end
            DATA: begin
                cur_byte  = data_q[{idx_q, 3'b000} +: 8];
                stuffable = 1'b1;
                crc_fed   = 1'b1;
            end
            CRC_L: begin
                cur_byte  = crc_q[7:0];
                stuffable = 1'b1;
            end
            CRC_H: begin
                cur_byte  = crc_q[15:8];
                stuffable = 1'b1;
            end
            ETX:     cur_byte = B_ETX;
            LSE:     cur_byte = B_LSE;
            CLSE:    cur_byte = B_CLSE;
            default: cur_byte = B_DLE;
        endcase
        // The inserted stuff symbol repeats 0xFE in the same state.
        if (stuff_q) cur_byte = B_DLE;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        n_d     = n_q;
        stuff_d = stuff_q;
        lt_d    = lt_q;
        crc_d   = crc_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        len_d   = len_q;
        data_d  = data_q;

        if (!sb.sb_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            stuff_d = 1'b0;
        end else if (!busy) begin
            if (accept) begin
                state_d = DLE_S;
                cnt_d   = '0;
                idx_d   = '0;
                stuff_d = 1'b0;
                crc_d   = 16'hFFFF;
                lt_d    = sb.lt_req;
                // LT takes priority; the AT request stays pending uncaptured.
                if (!sb.lt_req) begin
                    cmd_d  = sb.at_cmd;
                    addr_d = sb.at_addr;
                    len_d  = {sb.at_rw, sb.at_len};
                    data_d = sb.at_data;
                    if (sb.at_cmd && !sb.at_rw)           n_d = '0;
                    else if (sb.at_len > 7'(MAX_DATA))    n_d = CW'(MAX_DATA);
                    else                                  n_d = CW'(sb.at_len);
                end
            end
        end else begin
            cnt_d = sym_last ? '0 : cnt_q + SW'(1);
            if (sym_last) begin
                if (crc_fed && !stuff_q) crc_d = crc16_byte(crc_q, cur_byte);
                if (stuffable && !stuff_q && cur_byte == B_DLE) begin
                    stuff_d = 1'b1;
                end else begin
                    stuff_d = 1'b0;
                    case (state_q)
                        DLE_S: state_d = lt_q ? LSE : STX;
                        STX:   state_d = ADDR;
                        ADDR:  state_d = LEN;
                        LEN:   state_d = (n_q == '0) ? CRC_L : DATA;
                        DATA: begin
                            if (idx_q == n_q - CW'(1)) state_d = CRC_L;
                            else                       idx_d   = idx_q + CW'(1);
                        end
                        CRC_L: state_d = CRC_H;
                        CRC_H: state_d = DLE_E;
                        DLE_E: state_d = ETX;
                        LSE:   state_d = CLSE;
                        default: state_d = IDLE;  // ETX, CLSE complete the frame
                    endcase
                end
            end
        end
    end

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            stuff_q <= 1'b0;
            lt_q    <= 1'b0;
            crc_q   <= 16'hFFFF;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            stuff_q <= stuff_d;
            lt_q    <= lt_d;
            crc_q   <= crc_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    assign sb.busy      = busy;
    assign sb.sym_start = busy && (cnt_q == '0);
    assign sb.done      = busy && sym_last && sb.sb_en && (state_q == ETX || state_q == CLSE);
    assign sb.sbtx      = busy ? {1'b1, cur_byte, 1'b0} : 10'h3FF;

endmodule

// File: tb/tb_sb_transaction_tx.sv
// Self-checking bench for sb_transaction_tx: directed AT/LT frames, DLE
// stuffing, back-to-back frames, abort via sb_en and asynchronous reset.
module tb_sb_transaction_tx;

    localparam int SYM = 10;

    logic sb_clk = 1'b0;
    logic rst;

    sb_transaction_tx_if #(.MAX_DATA(3)) sb ();

    sb_transaction_tx #(.SYM_CYCLES(SYM), .MAX_DATA(3)) dut (
        .sb_clk (sb_clk),
        .rst    (rst),
        .sb     (sb)
    );

    always #5 sb_clk = ~sb_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int glitch = 0;

    logic [7:0] got_b[$];
    int         got_c[$];
    int         done_c[$];
    logic [7:0] exp_b[$];
    logic [9:0] prev_tx;

    always @(posedge sb_clk) cyc <= cyc + 1;

    // Lane monitor: records each symbol's byte and start cycle, done cycles,
    // and counts framing/stability violations.
    always @(negedge sb_clk) begin
        if (sb.busy === 1'b1) begin
            if (sb.sbtx[9] !== 1'b1 || sb.sbtx[0] !== 1'b0) glitch++;
            if (sb.sym_start === 1'b1) begin
                got_b.push_back(sb.sbtx[8:1]);
                got_c.push_back(cyc);
            end else if (sb.sbtx !== prev_tx) begin
                glitch++;
            end
        end else if (sb.sbtx !== 10'h3FF || sb.sym_start !== 1'b0) begin
            glitch++;
        end
        if (sb.done === 1'b1) done_c.push_back(cyc);
        prev_tx = sb.sbtx;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC: byte XORed into the high half, then 8 shifts.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    task automatic exp_push(input logic [7:0] b, input bit stuffable);
        exp_b.push_back(b);
        if (stuffable && b == 8'hFE) exp_b.push_back(8'hFE);
    endtask

    // nbytes is the hand-derived data byte count for the frame.
    task automatic exp_at(input bit cmd, input bit rw, input logic [7:0] addr,
                          input logic [6:0] len, input logic [23:0] data, input int nbytes);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        exp_push(8'hFE, 1'b0);
        b = cmd ? 8'h05 : 8'h04;
        exp_push(b, 1'b0);          c = crc_ref(c, b);
        exp_push(addr, 1'b1);       c = crc_ref(c, addr);
        b = {rw, len};
        exp_push(b, 1'b1);          c = crc_ref(c, b);
        for (int i = 0; i < nbytes; i++) begin
            b = data[8*i +: 8];
            exp_push(b, 1'b1);      c = crc_ref(c, b);
        end
        exp_push(c[7:0], 1'b1);
        exp_push(c[15:8], 1'b1);
        exp_push(8'hFE, 1'b0);
        exp_push(8'h40, 1'b0);
    endtask

    task automatic set_at(input bit cmd, input bit rw, input logic [7:0] addr,
                          input logic [6:0] len, input logic [23:0] data);
        sb.at_cmd  = cmd;
        sb.at_rw   = rw;
        sb.at_addr = addr;
        sb.at_len  = len;
        sb.at_data = data;
    endtask

    task automatic scramble_at();
        sb.at_cmd  = ~sb.at_cmd;
        sb.at_rw   = ~sb.at_rw;
        sb.at_addr = ~sb.at_addr;
        sb.at_len  = 7'h7F;
        sb.at_data = ~sb.at_data;
    endtask

    task automatic issue(input bit at, input bit lt, output int t);
        @(negedge sb_clk);
        sb.at_req = at;
        sb.lt_req = lt;
        t = cyc;
        @(negedge sb_clk);
        sb.lt_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.busy === 1'b1 && n < 400) begin
            @(negedge sb_clk);
            n++;
        end
        check_eq({tag, "_end"}, 32'(n < 400), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int t, input int b0, input int d0);
        int n;
        n = got_b.size() - b0;
        check_eq({tag, "_nsym"}, n, exp_b.size());
        for (int i = 0; i < exp_b.size() && i < n; i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), 32'(got_b[b0 + i]), 32'(exp_b[i]));
            check_eq($sformatf("%s_t%0d", tag, i), got_c[b0 + i], t + 1 + SYM * i);
        end
        check_eq({tag, "_ndone"}, done_c.size() - d0, 1);
        if (done_c.size() > d0)
            check_eq({tag, "_tdone"}, done_c[d0], t + SYM * exp_b.size());
    endtask

    initial begin
        int t, t2, b0, d0, seen;

        rst       = 1'b1;
        sb.sb_en  = 1'b1;
        sb.at_req = 1'b0;
        sb.lt_req = 1'b0;
        set_at(1'b0, 1'b0, 8'h00, 7'd0, 24'h0);
        repeat (3) @(negedge sb_clk);
        check_eq("rst_busy",  32'(sb.busy),      32'd0);
        check_eq("rst_done",  32'(sb.done),      32'd0);
        check_eq("rst_sym",   32'(sb.sym_start), 32'd0);
        check_eq("rst_sbtx",  32'(sb.sbtx),      32'h3FF);
        rst = 1'b0;
        @(negedge sb_clk);

        // Read command: no data bytes regardless of at_len.
        exp_b.delete();
        exp_at(1'b1, 1'b0, 8'h12, 7'd3, 24'h0, 0);
        set_at(1'b1, 1'b0, 8'h12, 7'd3, 24'h0);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b1, 1'b0, t);
        sb.at_req = 1'b0;
        scramble_at();
        wait_idle("rd");
        check_frame("rd", t, b0, d0);

        // Write command with a 0xFE data byte that must be stuffed.
        exp_b.delete();
        exp_at(1'b1, 1'b1, 8'h20, 7'd3, 24'h00FE11, 3);
        set_at(1'b1, 1'b1, 8'h20, 7'd3, 24'h00FE11);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b1, 1'b0, t);
        sb.at_req = 1'b0;
        scramble_at();
        wait_idle("wr");
        check_frame("wr", t, b0, d0);
        check_eq("wr_stuff_b5", 32'(got_b[b0 + 5]), 32'h0FE);
        check_eq("wr_stuff_b6", 32'(got_b[b0 + 6]), 32'h0FE);

        // Response with at_len above MAX_DATA: clamped to 3 bytes.
        exp_b.delete();
        exp_at(1'b0, 1'b0, 8'h33, 7'd5, 24'hABCDEF, 3);
        set_at(1'b0, 1'b0, 8'h33, 7'd5, 24'hABCDEF);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b1, 1'b0, t);
        sb.at_req = 1'b0;
        scramble_at();
        wait_idle("rsp");
        check_frame("rsp", t, b0, d0);
        check_eq("rsp_stx", 32'(got_b[b0 + 1]), 32'h04);
        check_eq("rsp_d0",  32'(got_b[b0 + 4]), 32'hEF);
        check_eq("rsp_d2",  32'(got_b[b0 + 6]), 32'hAB);

        // Write with at_len=0 and address 0xFE: DATA skipped, ADDR stuffed.
        exp_b.delete();
        exp_at(1'b1, 1'b1, 8'hFE, 7'd0, 24'hFFFFFF, 0);
        set_at(1'b1, 1'b1, 8'hFE, 7'd0, 24'hFFFFFF);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b1, 1'b0, t);
        sb.at_req = 1'b0;
        scramble_at();
        wait_idle("wr0");
        check_frame("wr0", t, b0, d0);

        // Simultaneous LT and AT: LT first, held AT follows after one idle cycle.
        exp_b.delete();
        exp_push(8'hFE, 1'b0);
        exp_push(8'h80, 1'b0);
        exp_push(8'h7F, 1'b0);
        set_at(1'b1, 1'b1, 8'h44, 7'd1, 24'h998855);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b1, 1'b1, t);
        wait_idle("lt");
        check_frame("lt", t, b0, d0);
        check_eq("lt_done_cyc", done_c[d0], t + 30);
        t2 = cyc;
        exp_b.delete();
        exp_at(1'b1, 1'b1, 8'h44, 7'd1, 24'h998855, 1);
        b0 = got_b.size(); d0 = done_c.size();
        @(negedge sb_clk);
        check_eq("b2b_busy", 32'(sb.busy), 32'd1);
        sb.at_req = 1'b0;
        scramble_at();
        wait_idle("b2b");
        check_eq("b2b_gap", t2, t + 31);
        check_frame("b2b", t2, b0, d0);

        // Abort in the CRC_L symbol, then requests ignored while sb_en=0.
        set_at(1'b1, 1'b1, 8'h0A, 7'd3, 24'h030201);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b1, 1'b0, t);
        sb.at_req = 1'b0;
        while (cyc < t + 73) @(negedge sb_clk);
        sb.sb_en = 1'b0;
        @(negedge sb_clk);
        check_eq("abort_busy", 32'(sb.busy), 32'd0);
        check_eq("abort_sbtx", 32'(sb.sbtx), 32'h3FF);
        sb.at_req = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge sb_clk);
            if (sb.busy !== 1'b0) seen++;
        end
        sb.at_req = 1'b0;
        check_eq("abort_nostart", seen, 0);
        check_eq("abort_nsym", got_b.size() - b0, 8);
        check_eq("abort_ndone", done_c.size() - d0, 0);
        sb.sb_en = 1'b1;
        @(negedge sb_clk);

        // Asynchronous reset during DATA, then a fresh LT frame.
        set_at(1'b1, 1'b1, 8'h0B, 7'd3, 24'h030201);
        issue(1'b1, 1'b0, t);
        sb.at_req = 1'b0;
        while (cyc < t + 45) @(negedge sb_clk);
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", 32'(sb.busy), 32'd0);
        check_eq("mrst_sbtx", 32'(sb.sbtx), 32'h3FF);
        @(negedge sb_clk);
        rst = 1'b0;
        exp_b.delete();
        exp_push(8'hFE, 1'b0);
        exp_push(8'h80, 1'b0);
        exp_push(8'h7F, 1'b0);
        b0 = got_b.size(); d0 = done_c.size();
        issue(1'b0, 1'b1, t);
        wait_idle("mrst_lt");
        check_frame("mrst_lt", t, b0, d0);

        check_eq("lane_glitch", glitch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
